// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B controller: one full-subtractor cell, one bit per clock, LSB first.
// Owns operand/result shift registers, the borrow flop, the bit counter and start/done handshake.

module full_sub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic borw_i,
  output logic y_o,
  output logic borw_o
);
  assign y_o    = a_i ^ b_i ^ borw_i;
  assign borw_o = (~a_i & b_i) | (~(a_i ^ b_i) & borw_i);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borw_out
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic             borw_q, borw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borw_out_q, borw_out_d;

  logic             y;
  logic             cell_borw;

  full_sub_cell u_cell (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .borw_i (borw_q),
    .y_o    (y),
    .borw_o (cell_borw)
  );

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    r_sr_d     = r_sr_q;
    borw_d     = borw_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    diff_d     = diff_q;
    borw_out_d = borw_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = A;
          b_sr_d  = B;
          borw_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        r_sr_d = {y, r_sr_q[WIDTH-1:1]};
        borw_d = cell_borw;
        cnt_d  = cnt_q + CW'(1);
        // Last bit: publish the completed word straight from the shift path.
        if (cnt_q == LAST) begin
          diff_d     = {y, r_sr_q[WIDTH-1:1]};
          borw_out_d = cell_borw;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      r_sr_q     <= '0;
      borw_q     <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      diff_q     <= '0;
      borw_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      r_sr_q     <= r_sr_d;
      borw_q     <= borw_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      diff_q     <= diff_d;
      borw_out_q <= borw_out_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign borw_out = borw_out_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8 (directed + sweep) and WIDTH=13 (sweep).

module tb_serial_sub_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, busy8, done8, bo8;
  logic [7:0]  a8, b8, diff8;
  logic        start13, busy13, done13, bo13;
  logic [12:0] a13, b13, diff13;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borw_out(bo8)
  );

  serial_sub_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .A(a13), .B(b13),
    .busy(busy13), .done(done13), .diff(diff13), .borw_out(bo13)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [8:0]  sb8[$];
  logic [13:0] sb13[$];
  int ndone8 = 0, ndone13 = 0;
  bit sweep8 = 0, sweep13 = 0;
  int last8 = -1, last13 = -1;

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && done8) begin
      ndone8++;
      check_val("sb8_has_entry", (sb8.size() > 0), 1);
      if (sb8.size() > 0) begin
        e = sb8.pop_front();
        check_val("diff8", diff8, e[7:0]);
        check_val("borw8", bo8, e[8]);
      end
      if (sweep8) begin
        if (last8 >= 0) check_val("spacing8", cyc - last8, 10);
        last8 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    logic [13:0] e;
    if (!rst && done13) begin
      ndone13++;
      check_val("sb13_has_entry", (sb13.size() > 0), 1);
      if (sb13.size() > 0) begin
        e = sb13.pop_front();
        check_val("diff13", diff13, e[12:0]);
        check_val("borw13", bo13, e[13]);
      end
      if (sweep13) begin
        if (last13 >= 0) check_val("spacing13", cyc - last13, 15);
        last13 = cyc;
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int lat;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    sb8.push_back({(a < b), 8'(a - b)});
    @(posedge clk); #1;
    check_val("busy_rise", busy8, 1);
    start8 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done8) begin lat = k; break; end
    end
    check_val("done_latency", lat, 8);
    @(posedge clk); #1;
    check_val("done_one_cycle", done8, 0);
    check_val("busy_fall", busy8, 0);
  endtask

  task automatic ignore_test();
    int d0;
    @(negedge clk);
    a8 = 8'h20; b8 = 8'h01; start8 = 1'b1;
    sb8.push_back({1'b0, 8'h1F});
    d0 = ndone8;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start8 = (k == 3 || k == 9);
      if (k >= 2) begin a8 = 8'hAA; b8 = 8'h55; end
    end
    start8 = 1'b0;
    check_val("one_done", ndone8 - d0, 1);
    check_val("no_extra_op", busy8, 0);
  endtask

  task automatic reset_test();
    int d0;
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; start8 = 1'b1;
    d0 = ndone8;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("rst_mid_busy", busy8, 0);
    check_val("rst_mid_done", done8, 0);
    check_val("rst_mid_diff", diff8, 0);
    check_val("rst_mid_borw", bo8, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_val("no_done_after_abort", ndone8 - d0, 0);
    op8(8'h10, 8'h01);
  endtask

  task automatic pick8(input int i, output logic [7:0] a, output logic [7:0] b);
    case (i)
      0: begin a = 8'h00; b = 8'h00; end
      1: begin a = 8'h00; b = 8'hFF; end
      2: begin a = 8'hFF; b = 8'h00; end
      3: begin a = 8'h80; b = 8'h7F; end
      default: begin a = 8'($urandom); b = 8'($urandom); end
    endcase
  endtask

  task automatic pick13(input int i, output logic [12:0] a, output logic [12:0] b);
    case (i)
      0: begin a = 13'h0000; b = 13'h0000; end
      1: begin a = 13'h0000; b = 13'h1FFF; end
      2: begin a = 13'h1FFF; b = 13'h0000; end
      3: begin a = 13'h1000; b = 13'h0FFF; end
      default: begin a = 13'($urandom); b = 13'($urandom); end
    endcase
  endtask

  task automatic sweep8_t();
    int pushed, guard;
    logic prev;
    logic [7:0] na, nb;
    pushed = 0; guard = 0;
    sweep8 = 1; last8 = -1;
    @(negedge clk);
    pick8(0, na, nb);
    a8 = na; b8 = nb; start8 = 1'b1;
    prev = busy8;
    while (pushed < 200 && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
      if (busy8 && !prev) begin
        sb8.push_back({(a8 < b8), 8'(a8 - b8)});
        pushed++;
        if (pushed == 200) start8 = 1'b0;
        else begin pick8(pushed, na, nb); a8 = na; b8 = nb; end
      end
      prev = busy8;
    end
    start8 = 1'b0;
    check_val("sweep8_accepts", pushed, 200);
    guard = 0;
    while (sb8.size() != 0 && guard < 100) begin @(negedge clk); guard++; end
    check_val("sweep8_drained", sb8.size(), 0);
    sweep8 = 0;
  endtask

  task automatic sweep13_t();
    int pushed, guard;
    logic prev;
    logic [12:0] na, nb;
    pushed = 0; guard = 0;
    sweep13 = 1; last13 = -1;
    @(negedge clk);
    pick13(0, na, nb);
    a13 = na; b13 = nb; start13 = 1'b1;
    prev = busy13;
    while (pushed < 200 && guard < 6000) begin
      @(posedge clk); #1;
      guard++;
      if (busy13 && !prev) begin
        sb13.push_back({(a13 < b13), 13'(a13 - b13)});
        pushed++;
        if (pushed == 200) start13 = 1'b0;
        else begin pick13(pushed, na, nb); a13 = na; b13 = nb; end
      end
      prev = busy13;
    end
    start13 = 1'b0;
    check_val("sweep13_accepts", pushed, 200);
    guard = 0;
    while (sb13.size() != 0 && guard < 100) begin @(negedge clk); guard++; end
    check_val("sweep13_drained", sb13.size(), 0);
    sweep13 = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start13 = 1'b0; a13 = '0; b13 = '0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", busy8, 0);
    check_val("rst_done", done8, 0);
    check_val("rst_diff", diff8, 0);
    check_val("rst_borw", bo8, 0);
    check_val("rst_busy13", busy13, 0);
    rst = 1'b0;

    op8(8'h05, 8'h03);
    op8(8'h03, 8'h05);
    op8(8'h00, 8'h01);
    op8(8'hFF, 8'hFF);
    ignore_test();
    reset_test();

    fork
      sweep8_t();
      sweep13_t();
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
